vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter CORDW, default 11, coordinate counter width in bits.
REQ-002 SHALL have parameter MODE0, default VGA_640X480_60, timing set used when mode_sel=0.
REQ-003 SHALL have parameter MODE1, default VGA_800X600_60, timing set used when mode_sel=1.
REQ-004 SHALL have port clk_pix  input  1  system clock; the design has one clock.
REQ-005 SHALL have port rst_pix_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_en  input  1  pixel-advance enable; counters step only when high.
REQ-007 SHALL have port mode_sel  input  1  requested mode, sampled only at frame end.
REQ-008 SHALL have port mode_act  output  1  mode currently in effect.
REQ-009 SHALL have ports sx, sy  output  CORDW each  horizontal and vertical position.
REQ-010 SHALL have ports hsync, vsync  output  1 each  syncs, polarity per active mode.
REQ-011 SHALL have port de  output  1  data enable, high in the active area.
REQ-012 SHALL have ports line, frame  output  1 each  start-of-line and start-of-frame strobes.

Function
REQ-013 SHALL derive per mode: H_TOT = h_active+h_fp+h_sync+h_bp; V_TOT likewise.
REQ-014 SHALL advance sx by 1 per clock with pix_en=1; at sx=H_TOT-1, sx wraps to 0 and sy advances.
REQ-015 SHALL wrap sy from V_TOT-1 to 0 on the same pix_en cycle as sx wraps.
REQ-016 SHALL hold sx, sy and mode_act unchanged on any clock with pix_en=0.
REQ-017 SHALL assert hsync (active level) for sx in [h_active+h_fp, h_active+h_fp+h_sync-1]; inactive elsewhere.
REQ-018 SHALL assert vsync (active level) for sy in [v_active+v_fp, v_active+v_fp+v_sync-1]; inactive elsewhere.
REQ-019 SHALL set the active level to high when the mode's pol bit is 1 and to low when it is 0.
REQ-020 SHALL drive de = (sx < h_active) && (sy < v_active).
REQ-021 SHALL drive line = pix_en && sx==0, and frame = pix_en && sx==0 && sy==0.
REQ-022 SHALL decode hsync, vsync, de, line and frame combinationally from the registered sx, sy and mode_act, with zero cycles of latency relative to them.
REQ-023 SHALL load mode_act from mode_sel only on a pix_en cycle with sx=H_TOT-1 and sy=V_TOT-1, so that the new mode applies from (0,0).
REQ-024 SHALL ignore mode_sel changes mid-frame, including toggles that return to the old value before frame end.
REQ-025 SHALL fail elaboration when any mode's H_TOT or V_TOT exceeds 2**CORDW.
REQ-026 SHALL never hold sx >= H_TOT or sy >= V_TOT of the active mode.

Reset
REQ-027 SHALL set sx=0, sy=0 and mode_act=0 asynchronously while rst_pix_n=0, independent of pix_en.
REQ-028 SHALL give, during reset, hsync and vsync at MODE0's inactive level, de=1, and line=frame=pix_en.
REQ-029 SHALL leave reset mid-frame with counting resuming at (0,0) in MODE0.

Structure
REQ-030 SHALL define typedef vga_timing_t in package vga_pkg with fields h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp (16-bit each), h_pol and v_pol.
REQ-031 SHALL define constants VGA_640X480_60 and VGA_800X600_60 in vga_pkg.
REQ-032 SHALL instantiate sub-module vga_axis_counter (count, wrap and sync/active decode) twice, once per axis.

Verification
REQ-033 SHALL cover: MODE0, pix_en=1 -> sx 0..799, hsync low for sx 656..751, sy 0..524, vsync low for sy 490..491, 800*525=420000 clocks per frame.
REQ-034 SHALL cover: mode_sel=1 set mid-frame -> mode_act=0 until the (799,524) step, then 800x600 timing with H_TOT 1056, hsync high for sx 840..967, and vsync high for sy 601..604.
REQ-035 SHALL cover: pix_en high every other clock -> sx, sy and strobes frozen on low cycles, and a frame takes 840000 clocks.
REQ-036 SHALL cover: rst_pix_n pulsed low at (300,200) in MODE1 -> immediate sx=sy=0 and mode_act=0, then MODE0 counting after release.
REQ-037 SHALL cover: frame strobe once per frame at (0,0), line strobe 525 times per frame, de high for 307200 pixels per frame in MODE0.

Source files
------------

// File: rtl/vga_pkg.sv
// VGA timing sets and the timing-descriptor type shared by the generator.
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0};

  localparam vga_timing_t VGA_800X600_60 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
    h_pol: 1'b1, v_pol: 1'b1};

  function automatic int unsigned h_total(vga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int unsigned v_total(vga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One axis of the raster: wrapping position counter plus sync/active decode.
module vga_axis_counter #(
  parameter int CORDW = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [15:0]      len_active,
  input  logic [15:0]      len_fp,
  input  logic [15:0]      len_sync,
  input  logic [16:0]      len_total,
  input  logic             pol,
  output logic [CORDW-1:0] pos,
  output logic             wrap,
  output logic             sync,
  output logic             act
);

  logic [16:0] p;
  logic [16:0] sync_start;
  logic [16:0] sync_end;

  assign p          = 17'(pos);
  assign sync_start = 17'(len_active) + 17'(len_fp);
  assign sync_end   = sync_start + 17'(len_sync);

  // >= rather than == keeps the counter bounded even if totals ever shrink
  assign wrap = (p >= len_total - 17'd1);
  assign act  = (p < 17'(len_active));
  assign sync = ((p >= sync_start) && (p < sync_end)) ? pol : ~pol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pos <= '0;
    else if (step) pos <= wrap ? '0 : pos + 1'b1;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Two-mode VGA raster timing generator; mode switches only at frame boundaries.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int          CORDW = 11,
  parameter vga_timing_t MODE0 = VGA_640X480_60,
  parameter vga_timing_t MODE1 = VGA_800X600_60
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             pix_en,
  input  logic             mode_sel,
  output logic             mode_act,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
);

  localparam longint unsigned COORD_SPAN = longint'(1) << CORDW;

  if (CORDW < 1 || CORDW > 16) begin : g_bad_cordw
    $error("vga_timing_gen: CORDW must be 1..16");
  end
  if (h_total(MODE0) > COORD_SPAN || v_total(MODE0) > COORD_SPAN ||
      h_total(MODE1) > COORD_SPAN || v_total(MODE1) > COORD_SPAN) begin : g_bad_tot
    $error("vga_timing_gen: mode totals exceed coordinate range");
  end

  vga_timing_t sel;
  logic [16:0] h_tot, v_tot;
  logic        h_wrap, v_wrap, h_act, v_act;

  assign sel   = mode_act ? MODE1 : MODE0;
  assign h_tot = 17'(sel.h_active) + 17'(sel.h_fp) + 17'(sel.h_sync) + 17'(sel.h_bp);
  assign v_tot = 17'(sel.v_active) + 17'(sel.v_fp) + 17'(sel.v_sync) + 17'(sel.v_bp);

  vga_axis_counter #(.CORDW(CORDW)) u_h (
    .clk(clk_pix), .rst_n(rst_pix_n), .step(pix_en),
    .len_active(sel.h_active), .len_fp(sel.h_fp), .len_sync(sel.h_sync),
    .len_total(h_tot), .pol(sel.h_pol),
    .pos(sx), .wrap(h_wrap), .sync(hsync), .act(h_act));

  vga_axis_counter #(.CORDW(CORDW)) u_v (
    .clk(clk_pix), .rst_n(rst_pix_n), .step(pix_en && h_wrap),
    .len_active(sel.v_active), .len_fp(sel.v_fp), .len_sync(sel.v_sync),
    .len_total(v_tot), .pol(sel.v_pol),
    .pos(sy), .wrap(v_wrap), .sync(vsync), .act(v_act));

  // new mode takes effect on the same edge that returns the raster to (0,0)
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n)                        mode_act <= 1'b0;
    else if (pix_en && h_wrap && v_wrap)   mode_act <= mode_sel;
  end

  assign de    = h_act && v_act;
  assign line  = pix_en && (sx == '0);
  assign frame = line && (sy == '0);

endmodule
